scalar_wb_arbiter: RTL and testbench
====================================

SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

Interface
REQ-001 SHALL have parameter SCALAR_REG_LEN, default 64, scalar write-back data width.
REQ-002 SHALL have parameter NUM_REQ, default 3, number of requesters: 0 = scalar ALU, 1 = load unit, 2 = vector-to-scalar move.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, both named as below.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- rdy_in  in  1  global advance enable.
- req_valid  in  NUM_REQ  write-back request per requester.
- req_rd  in  5*NUM_REQ  destination index per requester.
- req_data  in  SCALAR_REG_LEN*NUM_REQ  write-back data per requester.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- issue_valid  in  1  decode marks a new producer.
- issue_rd  in  5  producer destination.
- issue_ready  out  1  issue may proceed.
- rs1, rs2  in  5 each  decode source indices.
- rs1_busy, rs2_busy  out  1 each  source has a pending write.
- rf_signal  out  2  register-file command.
- rf_rd  out  5  register-file destination.
- rf_data  out  SCALAR_REG_LEN  register-file write data.
- write_back_enabled  out  1  register-file write strobe.
- pending  out  32  scoreboard bitmap.

Function
REQ-005 SHALL, in each cycle with rdy_in=1, grant at most one requester with req_valid=1; a transfer completes when req_valid and req_ready are both 1.
REQ-006 SHALL hold req_ready at 0 for every requester while rdy_in=0.
REQ-007 SHALL register a granted request into the output stage: rf_rd/rf_data equal the request, and write_back_enabled=1 for exactly one cycle, the cycle after the grant (latency 1).
REQ-008 SHALL drive rf_signal=`SCALAR_RF_WRITE while write_back_enabled=1 and rf_rd≠0; otherwise rf_signal=`RF_NOP.
REQ-009 SHALL accept a request with rd=0, load no data and leave write_back_enabled=0.
REQ-010 SHALL, while rdy_in=0, freeze the output stage, the scoreboard and the arbitration pointer.
REQ-011 SHALL, when rdy_in=1 and no request is valid, load write_back_enabled=0 and rf_signal=`RF_NOP.
REQ-012 SHALL set pending[issue_rd] at the clock edge when issue_valid=1, issue_ready=1, rdy_in=1 and issue_rd≠0.
REQ-013 SHALL clear pending[rf_rd] at the clock edge ending a cycle with write_back_enabled=1.
REQ-014 SHALL let the set win when a set and a clear target the same index at the same edge.
REQ-015 SHALL drive issue_ready=0 when issue_rd≠0 and pending[issue_rd]=1 (WAW stall); otherwise issue_ready=1.
REQ-016 SHALL compute rs1_busy = pending[rs1] AND rs1≠0, combinationally; rs2_busy likewise.
REQ-017 SHALL hold pending[0] at 0 permanently.

Reset
REQ-018 SHALL, while rst=0, asynchronously force: req_ready=0, write_back_enabled=0, rf_signal=`RF_NOP, rf_rd=0, rf_data=0, pending=0, arbitration pointer=0.
REQ-019 SHALL discard any in-flight grant when reset is asserted mid-operation, with no write issued after release.

Configuration
REQ-020 SHALL, with SCALAR_WB_RR_ARB_EN defined, arbitrate round-robin: after granting requester i, requester (i+1) mod NUM_REQ has highest priority.
REQ-021 SHALL, without SCALAR_WB_RR_ARB_EN, use fixed priority 0 > 1 > 2 and hold no pointer state.

Structure
REQ-022 SHALL take `SCALAR_RF_WRITE and `RF_NOP from the shared defines, and add requester-index constants (WB_REQ_ALU=0, WB_REQ_LOAD=1, WB_REQ_VEC=2) there.
REQ-023 SHALL place arbitration in one sub-module, wb_rr_arbiter, which takes valid, pointer and mode, and returns a one-hot grant.

Verification
REQ-024 SHALL check: reset released, no requests -> write_back_enabled=0, rf_signal=`RF_NOP, pending=0.
REQ-025 SHALL check: issue rd=5, then ALU writes rd=5, data=0x1234 -> pending[5]=1 and rs1_busy=1 for rs1=5; one cycle after the grant, write_back_enabled=1, rf_rd=5, rf_data=0x1234; the following cycle pending[5]=0.
REQ-026 SHALL check: all three requesters valid for 6 cycles with round-robin enabled -> grant order 0,1,2,0,1,2; with it disabled -> 0 on every cycle.
REQ-027 SHALL check: rd=7 pending and issue_rd=7 -> issue_ready=0; a same-edge clear of rd=7 plus a new issue to rd=7 -> pending[7]=1.
REQ-028 SHALL check: rdy_in=0 for 3 cycles during an active grant -> outputs and pending unchanged, req_ready=0; the grant resumes once rdy_in=1.
REQ-029 SHALL check: a load with rd=0 -> req_ready=1, write_back_enabled stays 0; rst asserted mid-grant -> no write after release.

Source files
------------

// File: rtl/scalar_wb_arbiter_pkg.sv
// ============================================================================
// scalar_wb_arbiter_pkg : RF command codes, requester indices, helpers
// Rev 1.0
// ============================================================================
`ifndef RF_NOP
`define RF_NOP 2'b00
`endif
`ifndef SCALAR_RF_WRITE
`define SCALAR_RF_WRITE 2'b01
`endif

`default_nettype none

package scalar_wb_arbiter_pkg;

  localparam int WB_REQ_ALU  = 0;
  localparam int WB_REQ_LOAD = 1;
  localparam int WB_REQ_VEC  = 2;

  typedef logic [4:0] reg_idx_t;
  typedef logic [1:0] rf_cmd_t;

  // Pointer width that stays legal even for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scalar_wb_arbiter_if.sv
// ============================================================================
// scalar_wb_arbiter_if : write-back request bus (valid/rd/data, ready)
// Rev 1.0
// ============================================================================
`default_nettype none

interface scalar_wb_arbiter_if #(
  parameter int SCALAR_REG_LEN = 64,
  parameter int NUM_REQ        = 3
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [5*NUM_REQ-1:0]              req_rd;
  logic [SCALAR_REG_LEN*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]                req_ready;

  modport master (output req_valid, req_rd, req_data, input req_ready);
  modport slave  (input req_valid, req_rd, req_data, output req_ready);
endinterface

`default_nettype wire

// File: rtl/scalar_wb_arbiter_rr.sv
// ============================================================================
// wb_rr_arbiter : one-hot grant, fixed priority (mode=0) or rotating (mode=1)
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_rr_arbiter
  import scalar_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] valid,
  input  wire logic [PTR_W-1:0]   pointer,
  input  wire logic               mode,
  output logic [NUM_REQ-1:0]      grant
);

  logic [PTR_W-1:0]     w_start;
  logic [2*NUM_REQ-1:0] w_dbl_valid;
  logic [2*NUM_REQ-1:0] w_dbl_grant;
  logic [NUM_REQ-1:0]   w_rot_valid;
  logic [NUM_REQ-1:0]   w_rot_grant;

  assign w_start     = (mode && (int'(pointer) < NUM_REQ)) ? pointer : '0;
  // Rotate so the priority holder sits at bit 0, pick lowest, rotate back.
  assign w_dbl_valid = {valid, valid} >> w_start;
  assign w_rot_valid = w_dbl_valid[NUM_REQ-1:0];

  always_comb begin
    w_rot_grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot_valid[k]) w_rot_grant = NUM_REQ'(1) << k;
    end
  end

  assign w_dbl_grant = {w_rot_grant, w_rot_grant} << w_start;
  assign grant       = w_dbl_grant[2*NUM_REQ-1:NUM_REQ];

endmodule

`default_nettype wire

// File: rtl/scalar_wb_arbiter.sv
// ============================================================================
// scalar_wb_arbiter : scalar write-back arbiter, output stage and scoreboard
// Option macro SCALAR_WB_RR_ARB_EN selects round-robin (else fixed 0>1>2).
// Rev 1.0
// ============================================================================
`default_nettype none

module scalar_wb_arbiter
  import scalar_wb_arbiter_pkg::*;
#(
  parameter int SCALAR_REG_LEN = 64,
  parameter int NUM_REQ        = 3
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      rdy_in,
  scalar_wb_arbiter_if.slave             req_bus,
  input  wire logic                      issue_valid,
  input  wire reg_idx_t                  issue_rd,
  output logic                           issue_ready,
  input  wire reg_idx_t                  rs1,
  input  wire reg_idx_t                  rs2,
  output logic                           rs1_busy,
  output logic                           rs2_busy,
  output rf_cmd_t                        rf_signal,
  output reg_idx_t                       rf_rd,
  output logic [SCALAR_REG_LEN-1:0]      rf_data,
  output logic                           write_back_enabled,
  output logic [31:0]                    pending
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [NUM_REQ-1:0]        w_arb_grant;
  logic [NUM_REQ-1:0]        w_grant;
  logic                      w_any;
  reg_idx_t                  w_sel_rd;
  logic [SCALAR_REG_LEN-1:0] w_sel_data;
  logic [PTR_W-1:0]          w_ptr;
  logic                      w_mode;
  logic [31:0]               w_pend_next;

  logic                      r_wbe;
  reg_idx_t                  r_rd;
  logic [SCALAR_REG_LEN-1:0] r_data;
  logic [31:0]               r_pend;

`ifdef SCALAR_WB_RR_ARB_EN
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_next;

  always_comb begin
    w_ptr_next = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) w_ptr_next = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_ptr <= '0;
    else if (rdy_in && w_any) r_ptr <= w_ptr_next;
  end

  assign w_ptr  = r_ptr;
  assign w_mode = 1'b1;
`else
  assign w_ptr  = '0;
  assign w_mode = 1'b0;
`endif

  wb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .valid   (req_bus.req_valid),
    .pointer (w_ptr),
    .mode    (w_mode),
    .grant   (w_arb_grant)
  );

  assign w_grant           = rdy_in ? w_arb_grant : '0;
  assign w_any             = |w_grant;
  assign req_bus.req_ready = rst ? w_grant : '0;

  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_rd   = req_bus.req_rd[5*k +: 5];
        w_sel_data = req_bus.req_data[SCALAR_REG_LEN*k +: SCALAR_REG_LEN];
      end
    end
  end

  // A granted rd=0 request is consumed but leaves the held rd/data untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wbe  <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else if (rdy_in) begin
      r_wbe <= w_any && (w_sel_rd != 5'd0);
      if (w_any && (w_sel_rd != 5'd0)) begin
        r_rd   <= w_sel_rd;
        r_data <= w_sel_data;
      end
    end
  end

  assign issue_ready = !((issue_rd != 5'd0) && r_pend[issue_rd]);

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_comb begin
    w_pend_next = r_pend;
    if (r_wbe) w_pend_next[r_rd] = 1'b0;
    if (issue_valid && issue_ready && (issue_rd != 5'd0)) w_pend_next[issue_rd] = 1'b1;
    w_pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_pend <= '0;
    else if (rdy_in) r_pend <= w_pend_next;
  end

  assign rs1_busy           = r_pend[rs1] && (rs1 != 5'd0);
  assign rs2_busy           = r_pend[rs2] && (rs2 != 5'd0);
  assign write_back_enabled = r_wbe;
  assign rf_rd              = r_rd;
  assign rf_data            = r_data;
  assign rf_signal          = (r_wbe && (r_rd != 5'd0)) ? `SCALAR_RF_WRITE : `RF_NOP;
  assign pending            = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_scalar_wb_arbiter.sv
// ============================================================================
// tb_scalar_wb_arbiter : vector table, corner sequences, randomized vs model
// Rev 1.0
// ============================================================================
`ifndef RF_NOP
`define RF_NOP 2'b00
`endif
`ifndef SCALAR_RF_WRITE
`define SCALAR_RF_WRITE 2'b01
`endif

`default_nettype none

module tb_scalar_wb_arbiter;
  import scalar_wb_arbiter_pkg::*;

  localparam int W = 64;
  localparam int N = 3;
`ifdef SCALAR_WB_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy_in;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic         issue_ready;
  logic [4:0]   rs1, rs2;
  logic         rs1_busy, rs2_busy;
  logic [1:0]   rf_signal;
  logic [4:0]   rf_rd;
  logic [W-1:0] rf_data;
  logic         wbe;
  logic [31:0]  pending;

  scalar_wb_arbiter_if #(.SCALAR_REG_LEN(W), .NUM_REQ(N)) bus ();

  scalar_wb_arbiter #(.SCALAR_REG_LEN(W), .NUM_REQ(N)) dut (
    .clk                (clk),
    .rst                (rst),
    .rdy_in             (rdy_in),
    .req_bus            (bus),
    .issue_valid        (issue_valid),
    .issue_rd           (issue_rd),
    .issue_ready        (issue_ready),
    .rs1                (rs1),
    .rs2                (rs2),
    .rs1_busy           (rs1_busy),
    .rs2_busy           (rs2_busy),
    .rf_signal          (rf_signal),
    .rf_rd              (rf_rd),
    .rf_data            (rf_data),
    .write_back_enabled (wbe),
    .pending            (pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester-side stimulus
  logic [4:0]   t_rd[N];
  logic [W-1:0] t_data[N];
  logic [N-1:0] t_valid;

  task automatic drive(input bit rdy, input logic [N-1:0] v, input bit iv,
                       input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
    rdy_in      = rdy;
    t_valid     = v;
    issue_valid = iv;
    issue_rd    = ird;
    rs1         = r1;
    rs2         = r2;
    bus.req_valid = v;
    bus.req_rd    = {t_rd[2], t_rd[1], t_rd[0]};
    bus.req_data  = {t_data[2], t_data[1], t_data[0]};
  endtask

  task automatic set_all(input logic [4:0] rd, input logic [W-1:0] data);
    for (int i = 0; i < N; i++) begin
      t_rd[i]   = rd;
      t_data[i] = data;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_all(5'd0, '0);
    drive(1'b1, '0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Behavioural reference model
  logic [31:0]  m_pend;
  int           m_ptr;
  bit           m_wbe;
  logic [4:0]   m_rd;
  logic [W-1:0] m_data;

  task automatic model_reset();
    m_pend = '0; m_ptr = 0; m_wbe = 1'b0; m_rd = '0; m_data = '0;
  endtask

  function automatic int model_grant();
    int start;
    if (!rdy_in) return -1;
    start = RR ? m_ptr : 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (((t_valid >> i) & 3'd1) != 3'd0) return i;
    end
    return -1;
  endfunction

  function automatic bit model_issue_ready();
    return !((issue_rd != 5'd0) && m_pend[issue_rd]);
  endfunction

  task automatic model_step();
    int g;
    logic [31:0] np;
    g = model_grant();
    if (!rdy_in) return;
    np = m_pend;
    if (m_wbe) np[m_rd] = 1'b0;
    if (issue_valid && model_issue_ready() && issue_rd != 5'd0) np[issue_rd] = 1'b1;
    m_pend = np;
    if (g >= 0) begin
      m_wbe = (t_rd[g] != 5'd0);
      if (t_rd[g] != 5'd0) begin
        m_rd   = t_rd[g];
        m_data = t_data[g];
      end
      if (RR) m_ptr = (g + 1) % N;
    end else begin
      m_wbe = 1'b0;
    end
  endtask

  // Directed vector table (single valid requester per row, so mode-agnostic)
  typedef struct {
    bit         rdy;
    logic [2:0] valid;
    logic [4:0] rd;
    logic [63:0] data;
    bit         iv;
    logic [4:0] ird;
    logic [4:0] rs;
    logic [2:0] e_ready;
    bit         e_iready;
    bit         e_busy;
    bit         e_wbe;
    logic [4:0] e_rfrd;
    logic [31:0] e_pend;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 3'b000, 5'd0, 64'h0,      1, 5'd5, 5'd5, 3'b000, 1, 0, 0, 5'd0, 32'h20};
    tbl[1] = '{1, 3'b001, 5'd5, 64'h1234,   0, 5'd5, 5'd5, 3'b001, 0, 1, 1, 5'd5, 32'h20};
    tbl[2] = '{1, 3'b000, 5'd0, 64'h0,      0, 5'd0, 5'd5, 3'b000, 1, 1, 0, 5'd5, 32'h00};
    tbl[3] = '{1, 3'b000, 5'd0, 64'h0,      1, 5'd7, 5'd7, 3'b000, 1, 0, 0, 5'd5, 32'h80};
    tbl[4] = '{1, 3'b010, 5'd7, 64'h77,     1, 5'd7, 5'd0, 3'b010, 0, 0, 1, 5'd7, 32'h80};
    tbl[5] = '{1, 3'b000, 5'd0, 64'h0,      0, 5'd7, 5'd7, 3'b000, 0, 1, 0, 5'd7, 32'h00};
    tbl[6] = '{1, 3'b100, 5'd7, 64'hBEEF,   0, 5'd7, 5'd7, 3'b100, 1, 0, 1, 5'd7, 32'h00};
    tbl[7] = '{1, 3'b000, 5'd0, 64'h0,      1, 5'd7, 5'd7, 3'b000, 1, 0, 0, 5'd7, 32'h80};
    tbl[8] = '{1, 3'b010, 5'd0, 64'hDEAD,   0, 5'd0, 5'd0, 3'b010, 1, 0, 0, 5'd7, 32'h80};
    tbl[9] = '{0, 3'b001, 5'd3, 64'h33,     1, 5'd9, 5'd7, 3'b000, 1, 1, 0, 5'd7, 32'h80};

    // Reset state
    do_reset();
    @(posedge clk); #1;
    chk("rst_wbe", wbe, 1'b0);
    chk("rst_sig", rf_signal, `RF_NOP);
    chk("rst_pend", pending, 32'h0);
    chk("rst_rfrd", rf_rd, 5'd0);
    chk("rst_ready", bus.req_ready, 3'b000);

    for (int r = 0; r < 10; r++) begin
      set_all(tbl[r].rd, tbl[r].data);
      drive(tbl[r].rdy, tbl[r].valid, tbl[r].iv, tbl[r].ird, tbl[r].rs, tbl[r].rs);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), bus.req_ready, tbl[r].e_ready);
      chk($sformatf("tbl%0d_iready", r), issue_ready, tbl[r].e_iready);
      chk($sformatf("tbl%0d_rs1busy", r), rs1_busy, tbl[r].e_busy);
      chk($sformatf("tbl%0d_rs2busy", r), rs2_busy, tbl[r].e_busy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_wbe", r), wbe, tbl[r].e_wbe);
      chk($sformatf("tbl%0d_sig", r), rf_signal, tbl[r].e_wbe ? `SCALAR_RF_WRITE : `RF_NOP);
      chk($sformatf("tbl%0d_rfrd", r), rf_rd, tbl[r].e_rfrd);
      chk($sformatf("tbl%0d_pend", r), pending, tbl[r].e_pend);
      if (tbl[r].e_wbe) chk($sformatf("tbl%0d_data", r), rf_data, tbl[r].data);
    end

    // Arbitration order with all requesters valid
    do_reset();
    for (int i = 0; i < N; i++) begin
      t_rd[i]   = 5'(i + 1);
      t_data[i] = 64'h100 + 64'(i);
    end
    drive(1'b1, 3'b111, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int c = 0; c < 6; c++) begin
      int exp_idx;
      exp_idx = RR ? (c % N) : WB_REQ_ALU;
      @(negedge clk);
      chk($sformatf("order%0d_grant", c), bus.req_ready, 3'(1 << exp_idx));
      @(posedge clk); #1;
      chk($sformatf("order%0d_rfrd", c), rf_rd, 5'(exp_idx + 1));
      chk($sformatf("order%0d_data", c), rf_data, 64'h100 + 64'(exp_idx));
    end

    // Stall with rdy_in=0 during an active grant
    do_reset();
    set_all(5'd0, '0);
    t_rd[WB_REQ_ALU] = 5'd9; t_data[WB_REQ_ALU] = 64'h9999;
    drive(1'b1, 3'b001, 1'b1, 5'd12, 5'd12, 5'd9);
    @(negedge clk);
    chk("stall_pre_ready", bus.req_ready, 3'b001);
    @(posedge clk); #1;
    chk("stall_pre_wbe", wbe, 1'b1);
    t_data[WB_REQ_ALU] = 64'hAAAA;
    drive(1'b0, 3'b001, 1'b1, 5'd13, 5'd12, 5'd9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_ready", c), bus.req_ready, 3'b000);
      @(posedge clk); #1;
      chk($sformatf("stall%0d_wbe", c), wbe, 1'b1);
      chk($sformatf("stall%0d_rfrd", c), rf_rd, 5'd9);
      chk($sformatf("stall%0d_data", c), rf_data, 64'h9999);
      chk($sformatf("stall%0d_pend", c), pending, 32'h1000);
    end
    drive(1'b1, 3'b001, 1'b0, 5'd0, 5'd12, 5'd9);
    @(negedge clk);
    chk("resume_ready", bus.req_ready, 3'b001);
    chk("resume_busy", rs1_busy, 1'b1);
    @(posedge clk); #1;
    chk("resume_wbe", wbe, 1'b1);
    chk("resume_data", rf_data, 64'hAAAA);

    // Reset asserted mid-grant
    do_reset();
    set_all(5'd0, '0);
    t_rd[WB_REQ_ALU] = 5'd4; t_data[WB_REQ_ALU] = 64'h44;
    drive(1'b1, 3'b001, 1'b1, 5'd6, 5'd0, 5'd0);
    @(posedge clk); #1;
    chk("midrst_wbe_before", wbe, 1'b1);
    @(negedge clk);
    chk("midrst_ready_before", bus.req_ready, 3'b001);
    rst = 1'b0;
    #1;
    chk("midrst_ready_async", bus.req_ready, 3'b000);
    chk("midrst_wbe_async", wbe, 1'b0);
    chk("midrst_rfrd_async", rf_rd, 5'd0);
    chk("midrst_pend_async", pending, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b1, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    chk("postrst_wbe0", wbe, 1'b0);
    @(posedge clk); #1;
    chk("postrst_wbe1", wbe, 1'b0);
    chk("postrst_sig", rf_signal, `RF_NOP);
    chk("postrst_pend", pending, 32'h0);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      chk("rnd_wbe", wbe, m_wbe);
      chk("rnd_sig", rf_signal, m_wbe ? `SCALAR_RF_WRITE : `RF_NOP);
      chk("rnd_rfrd", rf_rd, m_rd);
      chk("rnd_pend", pending, m_pend);
      if (m_wbe) chk("rnd_data", rf_data, m_data);
      for (int i = 0; i < N; i++) begin
        t_rd[i]   = 5'($urandom_range(0, 7));
        t_data[i] = {$urandom, $urandom};
      end
      drive(($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      @(negedge clk);
      begin
        int g;
        g = model_grant();
        chk("rnd_ready", bus.req_ready, (g >= 0) ? 3'(1 << g) : 3'b000);
      end
      chk("rnd_iready", issue_ready, model_issue_ready());
      chk("rnd_rs1busy", rs1_busy, m_pend[rs1] && rs1 != 5'd0);
      chk("rnd_rs2busy", rs2_busy, m_pend[rs2] && rs2 != 5'd0);
      model_step();
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
